photonic_switch_sequencer: RTL and testbench

PHOTONIC_SWITCH_SEQUENCER -- requirements
Module: photonic_switch_sequencer

---
 rtl/photonic_switch_sequencer_pkg.sv | 19 +
 rtl/photonic_switch_sequencer_pwm_gen.sv | 41 ++++
 rtl/photonic_switch_sequencer.sv | 146 ++++++++++++++
 tb/tb_photonic_switch_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/photonic_switch_sequencer_pkg.sv
// Shared types and default constants for the photonic switch sequencer.
package photonic_switch_sequencer_pkg;

    localparam int PSS_PERIOD         = 25;
    localparam int PSS_SETTLE_PERIODS = 8;
    localparam int PSS_DUTY_W         = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } pss_state_e;

    // Counter/index width that never collapses to zero bits.
    function automatic int pss_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/photonic_switch_sequencer_pwm_gen.sv
// Heater PWM generator: period counter, duty compare and period-start strobe.
module pss_pwm_gen
    import photonic_switch_sequencer_pkg::*;
#(
    parameter int PERIOD = PSS_PERIOD,
    parameter int DUTY_W = PSS_DUTY_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              run,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_out,
    output logic              pwm_freq,
    output logic              period_end
);

    localparam int CNT_W = pss_width(PERIOD);
    localparam int CMP_W = ((CNT_W > DUTY_W) ? CNT_W : DUTY_W) + 1;

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            if (!run || period_end) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign period_end = run && (count == CNT_W'(PERIOD - 1));
    // Both sides widened so a duty code at or above PERIOD holds the output high.
    assign pwm_out    = run && (CMP_W'(count) < CMP_W'(duty));
    assign pwm_freq   = run && (count == '0);

endmodule

// File: rtl/photonic_switch_sequencer.sv
// Photonic switch sequencer: arbitrates heater requests and drives one shared PWM.
// Define PSS_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module photonic_switch_sequencer
    import photonic_switch_sequencer_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int DUTY_W         = PSS_DUTY_W,
    parameter int PERIOD         = PSS_PERIOD,
    parameter int SETTLE_PERIODS = PSS_SETTLE_PERIODS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DUTY_W-1:0]       duty_in,
    output logic [N_REQ-1:0]              gnt,
    output logic [pss_width(N_REQ)-1:0]   active_ch,
    output logic                          busy,
    output logic                          done,
    output logic                          pwm_out,
    output logic                          pwm_freq
);

    localparam int IDX_W = pss_width(N_REQ);
    localparam int SET_W = pss_width(SETTLE_PERIODS);

    pss_state_e        state;
    logic [DUTY_W-1:0] duty_q;
    logic [SET_W-1:0]  settle_cnt;
    logic              period_end;

    logic [IDX_W-1:0]  start;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  pick_onehot;
    logic [DUTY_W-1:0] pick_duty;
    int                best_d;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        pick_duty   = '0;
        best_d      = N_REQ;
        for (int j = 0; j < N_REQ; j++) begin
            int d;
            d = j - int'(start);
            if (d < 0) d = d + N_REQ;
            if (req[j] && d < best_d) begin
                best_d     = d;
                pick_found = 1'b1;
                pick_idx   = IDX_W'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (pick_found && IDX_W'(j) == pick_idx) begin
                pick_onehot[j] = 1'b1;
                pick_duty      = duty_in[j*DUTY_W +: DUTY_W];
            end
        end
    end

`ifdef PSS_ROUND_ROBIN_EN
    // Pointer holds the index where the next search begins.
    logic [IDX_W-1:0] ptr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (en && state == ST_IDLE && pick_found) begin
            ptr <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    assign start = ptr;
`else
    assign start = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            active_ch  <= '0;
            duty_q     <= '0;
            settle_cnt <= '0;
        end else if (en) begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state      <= ST_RUN;
                        gnt        <= pick_onehot;
                        active_ch  <= pick_idx;
                        duty_q     <= pick_duty;
                        settle_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    // Losing the granted request abandons the grant without a done pulse.
                    if (!(|(req & gnt))) begin
                        state     <= ST_IDLE;
                        gnt       <= '0;
                        active_ch <= '0;
                        duty_q    <= '0;
                    end else if (period_end) begin
                        if (settle_cnt == SET_W'(SETTLE_PERIODS - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    gnt       <= '0;
                    active_ch <= '0;
                    duty_q    <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    gnt       <= '0;
                    active_ch <= '0;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    pss_pwm_gen #(
        .PERIOD (PERIOD),
        .DUTY_W (DUTY_W)
    ) u_pwm (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .run        (state == ST_RUN),
        .duty       (duty_q),
        .pwm_out    (pwm_out),
        .pwm_freq   (pwm_freq),
        .period_end (period_end)
    );

endmodule

// File: tb/tb_photonic_switch_sequencer.sv
// Directed self-checking bench for photonic_switch_sequencer at default parameters.
module tb_photonic_switch_sequencer;

    localparam int N_REQ   = 4;
    localparam int DUTY_W  = 5;
    localparam int PERIOD  = 25;
    localparam int SETTLE  = 8;
    localparam int RUN_CYC = PERIOD * SETTLE;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    en;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DUTY_W-1:0] duty_in;
    logic [N_REQ-1:0]        gnt;
    logic [1:0]              active_ch;
    logic                    busy;
    logic                    done;
    logic                    pwm_out;
    logic                    pwm_freq;

    int n_checks  = 0;
    int n_errs    = 0;
    int done_seen = 0;

    photonic_switch_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .duty_in   (duty_in),
        .gnt       (gnt),
        .active_ch (active_ch),
        .busy      (busy),
        .done      (done),
        .pwm_out   (pwm_out),
        .pwm_freq  (pwm_freq)
    );

    always #5 clk = ~clk;

    // done is sampled just before each edge, i.e. its value over the ending cycle.
    always @(posedge clk) if (done === 1'b1) done_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_duty(input int ch, input int val);
        duty_in[ch*DUTY_W +: DUTY_W] = DUTY_W'(val);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Entered at the negedge of RUN cycle 0; leaves at the negedge of the idle cycle after DONE.
    task automatic run_grant(input string tag, input int ch, input int duty, input int new_duty);
        int highs, freqs, pat_err, hold_err, hp;
        logic exp_pwm, exp_freq;
        highs = 0; freqs = 0; pat_err = 0; hold_err = 0;
        hp = (duty < PERIOD) ? duty : PERIOD;
        for (int c = 0; c < RUN_CYC; c++) begin
            exp_pwm  = ((c % PERIOD) < duty);
            exp_freq = ((c % PERIOD) == 0);
            if (pwm_out !== exp_pwm)   pat_err++;
            if (pwm_freq !== exp_freq) pat_err++;
            if (gnt !== 4'(1 << ch) || active_ch !== 2'(ch) || busy !== 1'b1 || done !== 1'b0)
                hold_err++;
            highs += int'(pwm_out === 1'b1);
            freqs += int'(pwm_freq === 1'b1);
            if (c == 1) set_duty(ch, new_duty);
            @(negedge clk);
        end
        check({tag, "_highs"},    highs,    8 * hp);
        check({tag, "_freqs"},    freqs,    SETTLE);
        check({tag, "_pattern"},  pat_err,  0);
        check({tag, "_hold"},     hold_err, 0);
        check({tag, "_done"},     done,     1);
        check({tag, "_done_gnt"}, gnt,      4'(1 << ch));
        check({tag, "_done_pwm"}, pwm_out,  0);
        check({tag, "_done_busy"}, busy,    1);
        @(negedge clk);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_gnt"},  gnt,  0);
        check({tag, "_idle_done"}, done, 0);
    endtask

    initial begin
        int snap, n, frz_err;
        logic [3:0] exp_gnt;

        reset   = 1'b0;
        en      = 1'b1;
        req     = '0;
        duty_in = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_gnt",    gnt,       0);
        check("rst_ch",     active_ch, 0);
        check("rst_busy",   busy,      0);
        check("rst_done",   done,      0);
        check("rst_pwm",    pwm_out,   0);
        check("rst_freq",   pwm_freq,  0);
        reset = 1'b1;
        @(negedge clk);

        // Basic grant on channel 0, duty 10; a mid-grant duty change must be ignored.
        set_duty(0, 10);
        req = 4'b0001;
        @(negedge clk);
        check("a_gnt",  gnt,       4'b0001);
        check("a_ch",   active_ch, 0);
        check("a_busy", busy,      1);
        check("a_freq", pwm_freq,  1);
        check("a_pwm",  pwm_out,   1);
        run_grant("a", 0, 10, 3);
        req = '0;

        // Duty boundaries: 0 is always low, 31 (>= PERIOD) always high.
        set_duty(1, 0);
        req = 4'b0010;
        @(negedge clk);
        run_grant("duty0", 1, 0, 0);
        req = '0;
        set_duty(2, 31);
        req = 4'b0100;
        @(negedge clk);
        run_grant("duty31", 2, 31, 31);
        req = '0;

        // All channels requesting continuously.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_duty(i, 10);
        req  = 4'b1111;
        snap = done_seen;
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
`ifdef PSS_ROUND_ROBIN_EN
            exp_gnt = 4'(1 << (g % N_REQ));
`else
            exp_gnt = 4'b0001;
`endif
            check($sformatf("arb_gnt%0d", g), gnt, exp_gnt);
            if (g < 4) repeat (RUN_CYC + 2) @(negedge clk);
        end
        check("arb_dones", done_seen - snap, 4);
        req = '0;
        @(negedge clk);
        @(negedge clk);

        // Abort: request dropped during RUN cycle 60.
        set_duty(0, 10);
        req = 4'b0001;
        @(negedge clk);
        snap = done_seen;
        repeat (60) @(negedge clk);
        req = '0;
        @(negedge clk);
        check("abort_busy", busy,      0);
        check("abort_gnt",  gnt,       0);
        check("abort_ch",   active_ch, 0);
        check("abort_pwm",  pwm_out,   0);
        check("abort_done", done,      0);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_seen - snap, 0);

        // Freeze for 7 cycles at RUN cycle 30 (count 5, duty 10 -> pwm high).
        req = 4'b0001;
        @(negedge clk);
        repeat (30) @(negedge clk);
        en = 1'b0;
        frz_err = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (gnt !== 4'b0001 || busy !== 1'b1 || pwm_out !== 1'b1 || pwm_freq !== 1'b0 || done !== 1'b0)
                frz_err++;
        end
        check("freeze_hold", frz_err, 0);
        en = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("freeze_done_delay", n + 7, RUN_CYC - 30 + 7);
        @(negedge clk);
        req = '0;
        @(negedge clk);

        // Reset mid-RUN (with en low) and a fresh grant after release.
        req = 4'b0001;
        @(negedge clk);
        repeat (50) @(negedge clk);
        snap  = done_seen;
        reset = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        check("mrst_gnt",  gnt,       0);
        check("mrst_ch",   active_ch, 0);
        check("mrst_busy", busy,      0);
        check("mrst_done", done,      0);
        check("mrst_pwm",  pwm_out,   0);
        check("mrst_freq", pwm_freq,  0);
        req = 4'b0100;
        set_duty(2, 20);
        reset = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        check("post_gnt",  gnt,       4'b0100);
        check("post_ch",   active_ch, 2);
        check("post_busy", busy,      1);
        check("post_pwm",  pwm_out,   1);
        check("post_freq", pwm_freq,  1);
        check("mrst_no_done", done_seen - snap, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
